// File: rtl/out_buffer_pkg.sv
// rtl/out_buffer_pkg.sv - shared FSM encoding and drop-counter helpers for out_buffer
package out_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACCEPT = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam int DROPCNT_W = 16;

    function automatic logic [DROPCNT_W-1:0] sat_inc(input logic [DROPCNT_W-1:0] v);
        return (v == {DROPCNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/out_fifo.sv
// rtl/out_fifo.sv - result FIFO with registered occupancy and combinational head read
module out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Push into a full FIFO is legal only alongside a pop: head is read before the slot is overwritten.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/out_buffer.sv
// rtl/out_buffer.sv - FP result output stage: FIFO, registered bus, 4-phase handshake
// Optional OUT_BUFFER_DROPCNT_EN adds a saturating dropCount port.
module out_buffer
    import out_buffer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         doneFP,
    input  logic [WIDTH-1:0]             result,
    input  logic                         resultAccepted,
    output logic [WIDTH-1:0]             outBus,
    output logic                         resultReady,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef OUT_BUFFER_DROPCNT_EN
    ,
    output logic [DROPCNT_W-1:0]         dropCount
`endif
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_bus_q, out_bus_d;
    logic [WIDTH-1:0] head;
    logic             pop, push, drop;

    assign pop  = (state_q == ST_LOAD);
    assign push = doneFP && (!full || pop);
    assign drop = doneFP && full && !pop;

    out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .pop   (pop),
        .wdata (result),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    always_comb begin
        state_d   = state_q;
        out_bus_d = out_bus_q;
        case (state_q)
            ST_IDLE:   if (!empty) state_d = ST_LOAD;
            ST_LOAD: begin
                out_bus_d = head;
                state_d   = ST_ACCEPT;
            end
            ST_ACCEPT: if (resultAccepted) state_d = ST_FINISH;
            ST_FINISH: if (!resultAccepted) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            out_bus_q <= '0;
        end else begin
            state_q   <= state_d;
            out_bus_q <= out_bus_d;
        end
    end

    assign outBus      = out_bus_q;
    assign resultReady = (state_q == ST_ACCEPT);

`ifdef OUT_BUFFER_DROPCNT_EN
    logic [DROPCNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_cnt_q <= '0;
        else      drop_cnt_q <= drop_cnt_d;
    end

    assign dropCount = drop_cnt_q;
    assign overflow  = (drop_cnt_q != '0);
`else
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q | drop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovf_q <= 1'b0;
        else      ovf_q <= ovf_d;
    end

    assign overflow = ovf_q;
`endif

endmodule
